// File: rtl/cache_port_arbiter.sv
`default_nettype none
// =============================================================================
// Module  : cache_port_arbiter
// Brief   : Round-robin sharing of one cache access port between two requesters,
//           with a per-access watchdog and saturating per-requester hit counters.
// Rev     : 1.0
// =============================================================================
module cache_port_arbiter #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  output logic              hit0,
  output logic              err0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic              hit1,
  output logic              err1,
  output logic              cache_start,
  output logic [ADDR_W-1:0] cache_addr,
  input  logic              cache_done,
  input  logic [DATA_W-1:0] cache_data,
  input  logic              cache_hit,
  output logic [CNT_W-1:0]  hit_cnt0,
  output logic [CNT_W-1:0]  hit_cnt1,
  output logic              busy
);

  localparam int                WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              hit0_q, hit0_d, hit1_q, hit1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic              win;
  logic              fin;
  logic [DATA_W-1:0] fin_data;
  logic              fin_hit;
  logic              fin_err;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    hit0_d   = hit0_q;
    hit1_d   = hit1_q;
    err0_d   = err0_q;
    err1_d   = err1_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    win      = 1'b0;
    fin      = 1'b0;
    fin_data = '0;
    fin_hit  = 1'b0;
    fin_err  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that did not win last time goes first.
          win     = (req0 && req1) ? ~last_q : req1;
          gnt_d   = win;
          last_d  = win;
          addr_d  = win ? addr1 : addr0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + 1'b1;
        if (cache_done) begin
          fin      = 1'b1;
          fin_data = cache_data;
          fin_hit  = cache_hit;
          state_d  = IDLE;
        end else if (wd_q == WD_LAST) begin
          fin     = 1'b1;
          fin_err = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fin) begin
      if (gnt_q) begin
        done1_d  = 1'b1;
        rdata1_d = fin_data;
        hit1_d   = fin_hit;
        err1_d   = fin_err;
        if (fin_hit && cnt1_q != CNT_MAX) cnt1_d = cnt1_q + 1'b1;
      end else begin
        done0_d  = 1'b1;
        rdata0_d = fin_data;
        hit0_d   = fin_hit;
        err0_d   = fin_err;
        if (fin_hit && cnt0_q != CNT_MAX) cnt0_d = cnt0_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      addr_q   <= '0;
      wd_q     <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      hit0_q   <= 1'b0;
      hit1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      hit0_q   <= hit0_d;
      hit1_q   <= hit1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end

  assign done0       = done0_q;
  assign done1       = done1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign hit0        = hit0_q;
  assign hit1        = hit1_q;
  assign err0        = err0_q;
  assign err1        = err1_q;
  assign hit_cnt0    = cnt0_q;
  assign hit_cnt1    = cnt1_q;
  assign cache_addr  = addr_q;
  assign cache_start = (state_q == ISSUE);
  assign busy        = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cache_port_arbiter.sv
`default_nettype none
// =============================================================================
// Module  : tb_cache_port_arbiter
// Brief   : Randomised cycle-by-cycle bench with a transaction-level model of the
//           arbiter, cache responder and hit counters.
// Rev     : 1.0
// =============================================================================
module tb_cache_port_arbiter;

  localparam int TO   = 8;
  localparam int CW   = 4;
  localparam int CMAX = 15;
  localparam int NCYC = 4000;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic [14:0] addr0, addr1;
  logic        done0, done1;
  logic [31:0] rdata0, rdata1;
  logic        hit0, hit1, err0, err1;
  logic        cache_start;
  logic [14:0] cache_addr;
  logic        cache_done;
  logic [31:0] cache_data;
  logic        cache_hit;
  logic [CW-1:0] hit_cnt0, hit_cnt1;
  logic        busy;

  cache_port_arbiter #(
    .ADDR_W(15), .DATA_W(32), .CNT_W(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .done0(done0), .rdata0(rdata0), .hit0(hit0), .err0(err0),
    .done1(done1), .rdata1(rdata1), .hit1(hit1), .err1(err1),
    .cache_start(cache_start), .cache_addr(cache_addr),
    .cache_done(cache_done), .cache_data(cache_data), .cache_hit(cache_hit),
    .hit_cnt0(hit_cnt0), .hit_cnt1(hit_cnt1), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Requester, responder and expected-outcome state.
  bit          rq [2];
  logic [14:0] ad [2];
  int          cyc;
  bit          infl;
  bit          win;
  bit          ptr;
  bit          is_done;
  logic [14:0] m_addr;
  int          s_cyc, done_at, resp_at, late_at, lat;
  bit          exp_err, exp_hit;
  logic [31:0] exp_data;
  int          cnt [2];
  logic [31:0] m_rdata [2];

  function automatic logic [14:0] pick_addr();
    case ($urandom_range(0, 2))
      0:       return 15'h0400;
      1:       return 15'h2400;
      default: return 15'($urandom);
    endcase
  endfunction

  task automatic drive_reqs();
    req0  = rq[0];
    addr0 = ad[0];
    req1  = rq[1];
    addr1 = ad[1];
  endtask

  initial begin
    rst = 1'b1; cache_done = 1'b0; cache_hit = 1'b0; cache_data = '0;
    rq = '{default: 1'b0};
    ad = '{default: 15'h0};
    drive_reqs();
    cyc = 0; infl = 1'b0; ptr = 1'b1; win = 1'b0;
    s_cyc = -1; done_at = -1; resp_at = -1; late_at = -1;
    exp_err = 1'b0; exp_hit = 1'b0; exp_data = '0; m_addr = '0;
    cnt = '{default: 0};
    m_rdata = '{default: 32'h0};
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < NCYC; k++) begin
      @(negedge clk);
      cyc++;
      is_done = infl && (cyc == done_at);
      if (is_done) begin
        m_rdata[win] = exp_err ? 32'h0 : exp_data;
        if (!exp_err && exp_hit && cnt[win] < CMAX) cnt[win]++;
      end

      check_val("cache_start", cache_start, infl && (cyc == s_cyc));
      check_val("busy", busy, infl && (cyc < done_at));
      check_val("done0", done0, is_done && !win);
      check_val("done1", done1, is_done && win);
      if (is_done) begin
        check_val("hit_flag", win ? hit1 : hit0, !exp_err && exp_hit);
        check_val("err_flag", win ? err1 : err0, exp_err);
      end
      check_val("rdata0", rdata0, m_rdata[0]);
      check_val("rdata1", rdata1, m_rdata[1]);
      check_val("hit_cnt0", hit_cnt0, cnt[0]);
      check_val("hit_cnt1", hit_cnt1, cnt[1]);
      if (infl) check_val("cache_addr", cache_addr, m_addr);

      // Occasional reset pulse: drops any in-flight access and all counts.
      if (cyc > 30 && $urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        rq = '{default: 1'b0};
        drive_reqs();
        cache_done = 1'b0; cache_hit = 1'b0; cache_data = '0;
        infl = 1'b0; ptr = 1'b1; late_at = -1;
        cnt = '{default: 0};
        m_rdata = '{default: 32'h0};
        continue;
      end
      rst = 1'b0;

      if (is_done) begin
        if ($urandom_range(0, 1) == 1) ad[win] = pick_addr();
        else rq[win] = 1'b0;
      end
      for (int n = 0; n < 2; n++) begin
        if (!rq[n] && $urandom_range(0, 2) == 0) begin
          rq[n] = 1'b1;
          ad[n] = pick_addr();
        end
      end
      drive_reqs();

      cache_done = 1'b0;
      cache_hit  = 1'($urandom);
      cache_data = $urandom;
      if (infl && cyc == resp_at) begin
        cache_done = 1'b1;
        cache_hit  = exp_hit;
        cache_data = exp_data;
      end else if (cyc == late_at ||
                   (!(infl && cyc < done_at) && $urandom_range(0, 9) == 0)) begin
        cache_done = 1'b1;
        cache_hit  = 1'b1;
      end

      if (is_done) infl = 1'b0;

      if (!infl && (rq[0] || rq[1])) begin
        win    = (rq[0] && rq[1]) ? ~ptr : rq[1];
        ptr    = win;
        m_addr = ad[win];
        s_cyc  = cyc + 1;
        infl   = 1'b1;
        if ($urandom_range(0, 6) == 0) begin
          exp_err = 1'b1;
          exp_hit = 1'b0;
          done_at = s_cyc + TO + 1;
          resp_at = -1;
          late_at = ($urandom_range(0, 1) == 1) ? done_at : -1;
        end else begin
          case ($urandom_range(0, 3))
            0, 1:    lat = $urandom_range(1, 2);
            2:       lat = TO;
            default: lat = $urandom_range(1, TO);
          endcase
          exp_err  = 1'b0;
          exp_hit  = ($urandom_range(0, 2) != 0);
          exp_data = $urandom;
          resp_at  = s_cyc + lat;
          done_at  = resp_at + 1;
          late_at  = -1;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
